// File: rtl/dmi_responder_if.sv
// DMI request/response channel between a DTM initiator (master) and a
// debug-module responder (slave).
interface dmi_responder_if;
  logic        debug_req_valid;
  logic        debug_req_ready;
  logic [6:0]  debug_req_bits_addr;
  logic [1:0]  debug_req_bits_op;
  logic [31:0] debug_req_bits_data;
  logic        debug_resp_valid;
  logic        debug_resp_ready;
  logic [1:0]  debug_resp_bits_resp;
  logic [31:0] debug_resp_bits_data;

  modport master (
    output debug_req_valid, debug_req_bits_addr, debug_req_bits_op,
           debug_req_bits_data, debug_resp_ready,
    input  debug_req_ready, debug_resp_valid, debug_resp_bits_resp,
           debug_resp_bits_data
  );

  modport slave (
    input  debug_req_valid, debug_req_bits_addr, debug_req_bits_op,
           debug_req_bits_data, debug_resp_ready,
    output debug_req_ready, debug_resp_valid, debug_resp_bits_resp,
           debug_resp_bits_data
  );
endinterface

// File: rtl/dmi_responder.sv
// DMI target: one outstanding request serviced against a scratch register
// window and an exit register, answered after a fixed latency.
module dmi_responder #(
  parameter logic [6:0]  ADDR_BASE    = 7'h04,
  parameter int unsigned NUM_REGS     = 8,
  parameter logic [6:0]  EXIT_ADDR    = 7'h7F,
  parameter int unsigned RESP_LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  dmi_responder_if.slave        dmi,
  output logic [31:0]           exit
);

  localparam int unsigned IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int unsigned CNT_W = (RESP_LATENCY > 1) ? $clog2(RESP_LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(RESP_LATENCY - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
  localparam logic [7:0] WIN_LO = {1'b0, ADDR_BASE};
  localparam logic [7:0] WIN_HI = WIN_LO + 8'(NUM_REGS);

  localparam logic [1:0] OP_NOP    = 2'd0;
  localparam logic [1:0] OP_READ   = 2'd1;
  localparam logic [1:0] OP_WRITE  = 2'd2;
  localparam logic [1:0] RESP_OK   = 2'd0;
  localparam logic [1:0] RESP_FAIL = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      regs_q [NUM_REGS];
  logic [31:0]      regs_d [NUM_REGS];
  logic [31:0]      exit_q, exit_d;
  logic             resp_valid_q, resp_valid_d;
  logic [1:0]       resp_code_q, resp_code_d;
  logic [31:0]      resp_data_q, resp_data_d;

  logic             accept_s;
  logic [7:0]       addr_ext_s;
  logic             in_window_s;
  logic             is_exit_s;
  logic [IDX_W-1:0] reg_idx_s;

  // Ready is decoded from the state; reset masks it so nothing is accepted while held.
  assign dmi.debug_req_ready      = (state_q == S_IDLE) && !reset;
  assign dmi.debug_resp_valid     = resp_valid_q;
  assign dmi.debug_resp_bits_resp = resp_code_q;
  assign dmi.debug_resp_bits_data = resp_data_q;
  assign exit                     = exit_q;

  assign accept_s    = dmi.debug_req_valid && dmi.debug_req_ready;
  assign addr_ext_s  = {1'b0, dmi.debug_req_bits_addr};
  assign in_window_s = (addr_ext_s >= WIN_LO) && (addr_ext_s < WIN_HI);
  assign is_exit_s   = (dmi.debug_req_bits_addr == EXIT_ADDR);
  assign reg_idx_s   = IDX_W'(addr_ext_s - WIN_LO);

  // State register and all datapath flops
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= CNT_ZERO;
      regs_q       <= '{default: 32'h0000_0000};
      exit_q       <= 32'h0000_0000;
      resp_valid_q <= 1'b0;
      resp_code_q  <= RESP_OK;
      resp_data_q  <= 32'h0000_0000;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      regs_q       <= regs_d;
      exit_q       <= exit_d;
      resp_valid_q <= resp_valid_d;
      resp_code_q  <= resp_code_d;
      resp_data_q  <= resp_data_d;
    end
  end

  // Next-state and latency counter
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (accept_s) begin
          if (RESP_LATENCY == 1) begin
            state_d = S_RESP;
            cnt_d   = CNT_ZERO;
          end else begin
            state_d = S_WAIT;
            cnt_d   = CNT_LOAD;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        if (cnt_q <= CNT_ONE) begin
          state_d = S_RESP;
          cnt_d   = CNT_ZERO;
        end else begin
          cnt_d   = cnt_q - CNT_ONE;
        end
      end
      S_RESP: begin
        if (dmi.debug_resp_ready) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_RESP;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = CNT_ZERO;
      end
    endcase
  end

  // Request decode at accept: response capture and register side effects
  always_comb begin
    regs_d       = regs_q;
    exit_d       = exit_q;
    resp_code_d  = resp_code_q;
    resp_data_d  = resp_data_q;
    resp_valid_d = (state_d == S_RESP);
    if (accept_s) begin
      resp_code_d = RESP_FAIL;
      resp_data_d = 32'h0000_0000;
      case (dmi.debug_req_bits_op)
        OP_NOP: begin
          resp_code_d = RESP_OK;
        end
        OP_READ: begin
          if (in_window_s) begin
            resp_code_d = RESP_OK;
            resp_data_d = regs_q[reg_idx_s];
          end else if (is_exit_s) begin
            resp_code_d = RESP_OK;
            resp_data_d = exit_q;
          end else begin
            resp_code_d = RESP_FAIL;
          end
        end
        OP_WRITE: begin
          if (in_window_s) begin
            regs_d[reg_idx_s] = dmi.debug_req_bits_data;
            resp_code_d       = RESP_OK;
            resp_data_d       = dmi.debug_req_bits_data;
          end else if (is_exit_s) begin
            exit_d      = dmi.debug_req_bits_data;
            resp_code_d = RESP_OK;
            resp_data_d = dmi.debug_req_bits_data;
          end else begin
            resp_code_d = RESP_FAIL;
          end
        end
        default: begin
          resp_code_d = RESP_FAIL;
        end
      endcase
    end else begin
      resp_code_d = resp_code_q;
    end
  end

endmodule
